// File: rtl/fetch_pc_gen_pkg.sv
// Shared types and constants for the IF-stage PC generator.
// Widths mirror the pipeline-wide bus definitions used by ID and ctrl.
package fetch_pc_gen_pkg;

  localparam logic [31:0] RESET_PC    = 32'hBFC0_0000;
  localparam int          IF_TO_ID_WD = 33;
  localparam int          BR_WD       = 33;
  localparam int          STALL_WD    = 6;
  localparam logic        STOP        = 1'b1;
  localparam logic        NO_STOP     = 1'b0;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  // The debug counter sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_pc_gen_if.sv
// Control and SRAM-facing bundle between the fetch stage and its neighbours.
interface fetch_pc_gen_if;
  import fetch_pc_gen_pkg::*;

  logic [STALL_WD-1:0]    stall;
  logic [BR_WD-1:0]       br_bus;
  logic [IF_TO_ID_WD-1:0] if_to_id_bus;
  logic                   inst_sram_en;
  logic [3:0]             inst_sram_wen;
  logic [31:0]            inst_sram_addr;
  logic [31:0]            inst_sram_wdata;
  logic [31:0]            fetch_cnt;

  modport master (
    input  stall, br_bus,
    output if_to_id_bus, inst_sram_en, inst_sram_wen,
           inst_sram_addr, inst_sram_wdata, fetch_cnt
  );

  modport slave (
    output stall, br_bus,
    input  if_to_id_bus, inst_sram_en, inst_sram_wen,
           inst_sram_addr, inst_sram_wdata, fetch_cnt
  );

endinterface

// File: rtl/fetch_pc_gen_br_hold_reg.sv
// Remembers a branch target that arrived while fetch was stalled until the
// stall releases; a later capture overwrites an earlier one.
module fetch_pc_gen_br_hold_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        capture,
  input  logic [31:0] capture_addr,
  input  logic        clear,
  output logic        pend_valid,
  output logic [31:0] pend_addr
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_valid <= 1'b0;
      pend_addr  <= 32'h0;
    end else if (capture) begin
      pend_valid <= 1'b1;
      pend_addr  <= capture_addr;
    end else if (clear) begin
      pend_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// IF stage: owns the PC, drives the instruction SRAM read port and passes
// {ce, pc} to ID. Redirects seen during a stall are parked, never dropped.
module fetch_pc_gen
  import fetch_pc_gen_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  fetch_pc_gen_if.master  bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         ce_q, ce_d;
  logic [31:0]  cnt_q, cnt_d;
  logic         capture, pend_clear;
  logic         pend_valid;
  logic [31:0]  pend_addr;
  logic [31:0]  next_pc;

  logic         br_e;
  logic [31:0]  br_addr;
  logic         stop;
  logic         unused_stall_hi;

  assign br_e            = bus.br_bus[32];
  assign br_addr         = bus.br_bus[31:0];
  assign stop            = (bus.stall[0] == STOP);
  assign unused_stall_hi = ^bus.stall[STALL_WD-1:1];

  fetch_pc_gen_br_hold_reg u_br_hold_reg (
    .clk          (clk),
    .rst          (rst),
    .capture      (capture),
    .capture_addr (br_addr),
    .clear        (pend_clear),
    .pend_valid   (pend_valid),
    .pend_addr    (pend_addr)
  );

  // A live redirect is newer than anything parked, so it wins.
  assign next_pc = br_e       ? br_addr   :
                   pend_valid ? pend_addr :
                                pc_q + 32'd4;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ce_d       = ce_q;
    cnt_d      = cnt_q;
    capture    = 1'b0;
    pend_clear = 1'b0;
    case (state_q)
      BOOT: begin
        if (!stop) begin
          pc_d    = RESET_PC;
          ce_d    = 1'b1;
          cnt_d   = 32'd1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!stop) begin
          pc_d  = next_pc;
          cnt_d = sat_inc(cnt_q);
        end else if (br_e) begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (stop) begin
          capture = br_e;
        end else begin
          pc_d       = next_pc;
          cnt_d      = sat_inc(cnt_q);
          pend_clear = 1'b1;
          state_d    = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC - 32'd4;
      ce_q    <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ce_q    <= ce_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.if_to_id_bus    = {ce_q, pc_q};
  assign bus.inst_sram_en    = ce_q;
  assign bus.inst_sram_wen   = 4'b0000;
  assign bus.inst_sram_addr  = pc_q;
  assign bus.inst_sram_wdata = 32'h0;
  assign bus.fetch_cnt       = cnt_q;

endmodule
